controlador_multiciclo: RTL
===========================

CONTROLADOR_MULTICICLO -- requirements
Module: controlador_multiciclo

Interface
REQ-001 Parameter MEM_WAIT, default 2, memory wait cycles per read; legal range 1..15.
REQ-002 Parameter STATE_W, default 6, width of the exported state code.
REQ-003 Clock  in  1  single clock; all registers rise-edge.
REQ-004 Reset  in  1  asynchronous, active-low (0 = reset asserted).
REQ-005 OpCode  in  6  IR[31:26] of the current instruction.
REQ-006 Zero  in  1  ALU zero flag, valid in the branch state.
REQ-007 PCEsc  out  1  PC write enable.
REQ-008 CtrMem  out  1  memory write (1) / read (0).
REQ-009 IREsc  out  1  instruction register load.
REQ-010 RegWrite  out  1  register file write.
REQ-011 RegDst  out  1  write index: 1 = rd, 0 = rt.
REQ-012 ULAFonteA  out  1  ALU A source: 0 = PC, 1 = reg A.
REQ-013 ULAFonteB  out  2  ALU B source: 00 = reg B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-014 ULAOp  out  2  ALU op class: 00 = add, 01 = sub, 10 = funct-decoded, 11 = idle.
REQ-015 FontePC  out  2  PC source: 01 = ULASaida register, 10 = jump target {PC[31:28], IR[25:0], 00}.
REQ-016 MemParaReg  out  1  write-back data: 1 = MDR, 0 = ULASaida.
REQ-017 IouD  out  1  memory address: 0 = PC, 1 = ULASaida.
REQ-018 RegACtrl / RegBCtrl  out  1 each  A/B register loads.
REQ-019 ULASaidaCtrl  out  1  ALU output register load.
REQ-020 MDRCtrl  out  1  memory data register load.
REQ-021 OpInvalido  out  1  one-cycle pulse on an unsupported opcode.
REQ-022 state  out  STATE_W  current state code, zero-extended.

Function
REQ-023 All outputs SHALL be Moore outputs (decoded from the state register only); unlisted outputs take their defaults: 0, FontePC = 01, ULAOp = 11.
REQ-024 BUSCA: IouD 0, ULAFonteA 0, ULAFonteB 01, ULAOp 00, ULASaidaCtrl 1 -> ESPERA_BUSCA with wait counter loaded to MEM_WAIT-1.
REQ-025 ESPERA_BUSCA: decrement counter; PCEsc 1 only in the first cycle (counter = MEM_WAIT-1); exit to ESCREVE_IR when counter = 0; dwell is exactly MEM_WAIT cycles.
REQ-026 ESCREVE_IR: IREsc 1 -> DECODE.
REQ-027 DECODE: RegACtrl 1, RegBCtrl 1, ULAFonteA 0, ULAFonteB 11, ULAOp 00, ULASaidaCtrl 1 (branch target precomputed); dispatch on OpCode.
REQ-028 Dispatch: 000000 -> R_EXEC; 100011 (lw) / 101011 (sw) / 001000 (addi) -> CALC_END; 000100 (beq) / 000101 (bne) -> DESVIO; 000010 (j) -> SALTO; other -> INVALIDO.
REQ-029 CALC_END: ULAFonteA 1, ULAFonteB 10, ULAOp 00, ULASaidaCtrl 1 -> LW_LEITURA (lw), SW_ESCRITA (sw), ADDI_FIM (addi).
REQ-030 LW_LEITURA: IouD 1, counter loaded to MEM_WAIT-1 on entry, dwell MEM_WAIT cycles -> LW_MDR (MDRCtrl 1) -> LW_FIM (RegWrite 1, MemParaReg 1, RegDst 0) -> BUSCA.
REQ-031 SW_ESCRITA: CtrMem 1 and IouD 1 for exactly one cycle -> BUSCA.
REQ-032 R_EXEC: ULAFonteA 1, ULAFonteB 00, ULAOp 10, ULASaidaCtrl 1 -> R_FIM (RegWrite 1, RegDst 1, MemParaReg 0) -> BUSCA.
REQ-033 ADDI_FIM: RegWrite 1, RegDst 0, MemParaReg 0 -> BUSCA.
REQ-034 DESVIO: ULAFonteA 1, ULAFonteB 00, ULAOp 01, FontePC 01; PCEsc = Zero for beq, !Zero for bne (the opcode is held stable in IR) -> BUSCA.
REQ-035 SALTO: FontePC 10, PCEsc 1 -> BUSCA.
REQ-036 INVALIDO: OpInvalido 1 for one cycle, no architectural write -> BUSCA.
REQ-037 Undefined state codes SHALL return to BUSCA on the next edge with default outputs.

Reset
REQ-038 Reset low SHALL force state to BUSCA and the counter to 0 immediately, independent of Clock; outputs take BUSCA values, so CtrMem, RegWrite and PCEsc drop at once even mid-store or mid-write-back.
REQ-039 The first BUSCA cycle SHALL occur on the first rising edge after Reset deasserts.

Structure
REQ-040 The state enum, opcode localparams, and ULAOp/FontePC/ULAFonteB encodings SHALL live in package controlador_pkg.
REQ-041 The wait counter SHALL be sub-module contador_espera (width $clog2(MEM_WAIT+1), ports load/value/done).

Verification
REQ-042 MEM_WAIT=2, R-type (OpCode 000000): BUSCA to R_FIM is 7 cycles; PCEsc pulses once in cycle 2; RegWrite=1, RegDst=1 in cycle 7.
REQ-043 MEM_WAIT=3, lw: LW_LEITURA holds IouD=1 for 3 cycles, then MDRCtrl for 1 cycle, then RegWrite=1 with MemParaReg=1; 12 cycles total.
REQ-044 beq with Zero=1 gives PCEsc=1 in DESVIO; bne with Zero=1 gives PCEsc=0; j gives FontePC=10, PCEsc=1.
REQ-045 OpCode 111111: OpInvalido=1 for exactly 1 cycle, RegWrite and CtrMem stay 0, then BUSCA.
REQ-046 Reset pulled low mid-SW_ESCRITA (between edges): CtrMem falls to 0 at once; state = 0 (BUSCA) without a clock edge.

Source files
------------

// File: rtl/controlador_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit:
// state codes, opcodes, ALU/PC source encodings and the control word.
package controlador_pkg;

  typedef enum logic [3:0] {
    BUSCA        = 4'd0,
    ESPERA_BUSCA = 4'd1,
    ESCREVE_IR   = 4'd2,
    DECODE       = 4'd3,
    CALC_END     = 4'd4,
    LW_LEITURA   = 4'd5,
    LW_MDR       = 4'd6,
    LW_FIM       = 4'd7,
    SW_ESCRITA   = 4'd8,
    R_EXEC       = 4'd9,
    R_FIM        = 4'd10,
    ADDI_FIM     = 4'd11,
    DESVIO       = 4'd12,
    SALTO        = 4'd13,
    INVALIDO     = 4'd14
  } estado_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] ULA_SOMA   = 2'b00;
  localparam logic [1:0] ULA_SUB    = 2'b01;
  localparam logic [1:0] ULA_FUNCT  = 2'b10;
  localparam logic [1:0] ULA_OCIOSA = 2'b11;

  localparam logic [1:0] PC_ULASAIDA = 2'b01;
  localparam logic [1:0] PC_SALTO    = 2'b10;

  localparam logic [1:0] FB_REG_B   = 2'b00;
  localparam logic [1:0] FB_QUATRO  = 2'b01;
  localparam logic [1:0] FB_IMM     = 2'b10;
  localparam logic [1:0] FB_IMM_SH2 = 2'b11;

  typedef struct packed {
    logic       pc_esc;
    logic       ctr_mem;
    logic       ir_esc;
    logic       reg_write;
    logic       reg_dst;
    logic       ula_fonte_a;
    logic [1:0] ula_fonte_b;
    logic [1:0] ula_op;
    logic [1:0] fonte_pc;
    logic       mem_para_reg;
    logic       iou_d;
    logic       reg_a_ctrl;
    logic       reg_b_ctrl;
    logic       ula_saida_ctrl;
    logic       mdr_ctrl;
    logic       op_invalido;
  } sinais_t;

  function automatic sinais_t sinais_padrao();
    sinais_t s;
    s          = '0;
    s.fonte_pc = PC_ULASAIDA;
    s.ula_op   = ULA_OCIOSA;
    return s;
  endfunction

endpackage

// File: rtl/controlador_multiciclo_if.sv
// Control bus between the multicycle controller (master) and the datapath (slave).
interface controlador_multiciclo_if;
    logic [5:0] OpCode;
    logic       Zero;
    logic       PCEsc;
    logic       CtrMem;
    logic       IREsc;
    logic       RegWrite;
    logic       RegDst;
    logic       ULAFonteA;
    logic [1:0] ULAFonteB;
    logic [1:0] ULAOp;
    logic [1:0] FontePC;
    logic       MemParaReg;
    logic       IouD;
    logic       RegACtrl;
    logic       RegBCtrl;
    logic       ULASaidaCtrl;
    logic       MDRCtrl;
    logic       OpInvalido;

    modport master (
        input  OpCode, Zero,
        output PCEsc, CtrMem, IREsc, RegWrite, RegDst, ULAFonteA, ULAFonteB, ULAOp,
               FontePC, MemParaReg, IouD, RegACtrl, RegBCtrl, ULASaidaCtrl, MDRCtrl,
               OpInvalido
    );

    modport slave (
        output OpCode, Zero,
        input  PCEsc, CtrMem, IREsc, RegWrite, RegDst, ULAFonteA, ULAFonteB, ULAOp,
               FontePC, MemParaReg, IouD, RegACtrl, RegBCtrl, ULASaidaCtrl, MDRCtrl,
               OpInvalido
    );
endinterface

// File: rtl/contador_espera.sv
// Memory wait-state down counter: load sets MEM_WAIT-1, then counts down and holds at 0.
module contador_espera #(
    parameter int MEM_WAIT = 2,
    parameter int CNT_W    = $clog2(MEM_WAIT + 1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    output logic [CNT_W-1:0] value,
    output logic             done
);
    localparam logic [CNT_W-1:0] CARGA = CNT_W'(MEM_WAIT - 1);

    assign done = (value == '0);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            value <= '0;
        end else if (load) begin
            value <= CARGA;
        end else if (!done) begin
            value <= value - CNT_W'(1);
        end
    end
endmodule

// File: rtl/controlador_multiciclo.sv
// Multicycle MIPS control unit: Moore FSM with a variable memory wait on fetch and load.
module controlador_multiciclo #(
    parameter int MEM_WAIT = 2,
    parameter int STATE_W  = 6
) (
    input  logic                 Clock,
    input  logic                 Reset,
    controlador_multiciclo_if.master bus,
    output logic [STATE_W-1:0]   state
);
    import controlador_pkg::*;

    localparam int               CNT_W    = $clog2(MEM_WAIT + 1);
    localparam logic [CNT_W-1:0] PRIMEIRO = CNT_W'(MEM_WAIT - 1);

    estado_t          estado, proximo;
    sinais_t          s;
    logic             carga;
    logic             fim_espera;
    logic [CNT_W-1:0] contagem;

    contador_espera #(.MEM_WAIT(MEM_WAIT), .CNT_W(CNT_W)) u_contador (
        .Clock (Clock),
        .Reset (Reset),
        .load  (carga),
        .value (contagem),
        .done  (fim_espera)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) estado <= BUSCA;
        else        estado <= proximo;
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        proximo = BUSCA;
        carga   = 1'b0;
        s       = sinais_padrao();
        case (estado)
            BUSCA: begin
                s.ula_fonte_b    = FB_QUATRO;
                s.ula_op         = ULA_SOMA;
                s.ula_saida_ctrl = 1'b1;
                carga            = 1'b1;
                proximo          = ESPERA_BUSCA;
            end
            ESPERA_BUSCA: begin
                // PC takes PC+4 once, in the first wait cycle only
                s.pc_esc = (contagem == PRIMEIRO);
                proximo  = fim_espera ? ESCREVE_IR : ESPERA_BUSCA;
            end
            ESCREVE_IR: begin
                s.ir_esc = 1'b1;
                proximo  = DECODE;
            end
            DECODE: begin
                s.reg_a_ctrl     = 1'b1;
                s.reg_b_ctrl     = 1'b1;
                s.ula_fonte_b    = FB_IMM_SH2;
                s.ula_op         = ULA_SOMA;
                s.ula_saida_ctrl = 1'b1;
                case (bus.OpCode)
                    OP_R:                  proximo = R_EXEC;
                    OP_LW, OP_SW, OP_ADDI: proximo = CALC_END;
                    OP_BEQ, OP_BNE:        proximo = DESVIO;
                    OP_J:                  proximo = SALTO;
                    default:               proximo = INVALIDO;
                endcase
            end
            CALC_END: begin
                s.ula_fonte_a    = 1'b1;
                s.ula_fonte_b    = FB_IMM;
                s.ula_op         = ULA_SOMA;
                s.ula_saida_ctrl = 1'b1;
                carga            = 1'b1;
                case (bus.OpCode)
                    OP_LW:   proximo = LW_LEITURA;
                    OP_SW:   proximo = SW_ESCRITA;
                    default: proximo = ADDI_FIM;
                endcase
            end
            LW_LEITURA: begin
                s.iou_d = 1'b1;
                proximo = fim_espera ? LW_MDR : LW_LEITURA;
            end
            LW_MDR: begin
                s.mdr_ctrl = 1'b1;
                proximo    = LW_FIM;
            end
            LW_FIM: begin
                s.reg_write    = 1'b1;
                s.mem_para_reg = 1'b1;
            end
            SW_ESCRITA: begin
                s.ctr_mem = 1'b1;
                s.iou_d   = 1'b1;
            end
            R_EXEC: begin
                s.ula_fonte_a    = 1'b1;
                s.ula_fonte_b    = FB_REG_B;
                s.ula_op         = ULA_FUNCT;
                s.ula_saida_ctrl = 1'b1;
                proximo          = R_FIM;
            end
            R_FIM: begin
                s.reg_write = 1'b1;
                s.reg_dst   = 1'b1;
            end
            ADDI_FIM: s.reg_write = 1'b1;
            DESVIO: begin
                s.ula_fonte_a = 1'b1;
                s.ula_fonte_b = FB_REG_B;
                s.ula_op      = ULA_SUB;
                s.fonte_pc    = PC_ULASAIDA;
                s.pc_esc      = (bus.OpCode == OP_BNE) ? !bus.Zero : bus.Zero;
            end
            SALTO: begin
                s.fonte_pc = PC_SALTO;
                s.pc_esc   = 1'b1;
            end
            INVALIDO: s.op_invalido = 1'b1;
            default:  proximo = BUSCA;
        endcase
    end

    assign bus.PCEsc        = s.pc_esc;
    assign bus.CtrMem       = s.ctr_mem;
    assign bus.IREsc        = s.ir_esc;
    assign bus.RegWrite     = s.reg_write;
    assign bus.RegDst       = s.reg_dst;
    assign bus.ULAFonteA    = s.ula_fonte_a;
    assign bus.ULAFonteB    = s.ula_fonte_b;
    assign bus.ULAOp        = s.ula_op;
    assign bus.FontePC      = s.fonte_pc;
    assign bus.MemParaReg   = s.mem_para_reg;
    assign bus.IouD         = s.iou_d;
    assign bus.RegACtrl     = s.reg_a_ctrl;
    assign bus.RegBCtrl     = s.reg_b_ctrl;
    assign bus.ULASaidaCtrl = s.ula_saida_ctrl;
    assign bus.MDRCtrl      = s.mdr_ctrl;
    assign bus.OpInvalido   = s.op_invalido;
    assign state            = STATE_W'(estado);
endmodule
